// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8-register datapath: one instruction per start pulse.
// Optional illegal-instruction trap state enabled by DATAPATH_CTRL_TRAP_EN.
module datapath_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        err,
  output logic        vsel,
  output logic        write,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        loada,
  output logic        loadb,
  output logic [1:0]  shift,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WRITE_REG,
`ifdef DATAPATH_CTRL_TRAP_EN
    S_WRITE_IMM,
    S_TRAP
`else
    S_WRITE_IMM
`endif
  } state_t;

  state_t      state;
  state_t      next;
  logic [15:0] ir;

  logic [2:0] opc;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  assign datapath_in = {{8{ir[7]}}, ir[7:0]};

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;
  logic is_mvn;
  logic unary;

  assign is_mov_imm = (opc == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opc == 3'b110) && (op == 2'b00);
  assign is_alu     = (opc == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign unary      = is_mov_reg || is_mvn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= next;
      if (state == S_WAIT && s)
        ir <= instr;
    end
  end

  always_comb begin
    next     = state;
    w        = 1'b0;
    err      = 1'b0;
    vsel     = 1'b0;
    write    = 1'b0;
    writenum = 3'b000;
    readnum  = 3'b000;
    loada    = 1'b0;
    loadb    = 1'b0;
    shift    = 2'b00;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    loadc    = 1'b0;
    loads    = 1'b0;
    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s)
          next = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)
          next = S_WRITE_IMM;
        else if (unary)
          next = S_GET_B;
        else if (is_alu)
          next = S_GET_A;
        else
`ifdef DATAPATH_CTRL_TRAP_EN
          next = S_TRAP;
`else
          next = S_WAIT;
`endif
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        next    = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        next    = S_EXEC;
      end
      S_EXEC: begin
        shift = sh;
        asel  = unary;
        // MOV reg is an add of zero and the shifted operand
        ALUop = is_mov_reg ? 2'b00 : op;
        if (is_cmp) begin
          loads = 1'b1;
          next  = S_WAIT;
        end else begin
          loadc = 1'b1;
          next  = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
        next     = S_WAIT;
      end
      S_WRITE_IMM: begin
        vsel     = 1'b1;
        writenum = rn;
        write    = 1'b1;
        next     = S_WAIT;
      end
`ifdef DATAPATH_CTRL_TRAP_EN
      S_TRAP: begin
        err  = 1'b1;
        next = S_TRAP;
      end
`endif
      default: begin
        next = S_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench: controller driving a behavioural datapath model.
// Regfile contents and controller outputs are checked against hand values.
module tb_datapath_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic        err;
  logic        vsel;
  logic        write;
  logic [2:0]  writenum;
  logic [2:0]  readnum;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [15:0] datapath_in;

  datapath_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s),
    .instr(instr),
    .w(w),
    .err(err),
    .vsel(vsel),
    .write(write),
    .writenum(writenum),
    .readnum(readnum),
    .loada(loada),
    .loadb(loadb),
    .shift(shift),
    .asel(asel),
    .bsel(bsel),
    .ALUop(ALUop),
    .loadc(loadc),
    .loads(loads),
    .datapath_in(datapath_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        init;
  logic [15:0] rf [8];
  logic [15:0] ra;
  logic [15:0] rb;
  logic [15:0] rc;
  logic        z;
  logic [15:0] sh_out;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [15:0] alu_out;

  always_comb begin
    sh_out = rb;
    case (shift)
      2'b01: sh_out = {rb[14:0], 1'b0};
      2'b10: sh_out = {1'b0, rb[15:1]};
      2'b11: sh_out = {rb[15], rb[15:1]};
      default: sh_out = rb;
    endcase
    ain = asel ? 16'h0 : ra;
    bin = bsel ? datapath_in : sh_out;
    case (ALUop)
      2'b00: alu_out = ain + bin;
      2'b01: alu_out = ain - bin;
      2'b10: alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 8; i++)
        rf[i] <= 16'h0;
      ra <= 16'h0;
      rb <= 16'h0;
      rc <= 16'h0;
      z  <= 1'b0;
    end else begin
      if (write)
        rf[writenum] <= vsel ? datapath_in : rc;
      if (loada)
        ra <= rf[readnum];
      if (loadb)
        rb <= rf[readnum];
      if (loadc)
        rc <= alu_out;
      if (loads)
        z <= (alu_out == 16'h0);
    end
  end

  logic watch;
  logic seen;
  always @(posedge clk) begin
    if (watch && (write || loada || loadb || loadc || loads))
      seen <= 1'b1;
  end

  int n_chk;
  int n_ok;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_ok++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [17:0] strobes();
    return {vsel, write, loada, loadb, asel, bsel, loadc, loads,
            writenum, readnum, shift, ALUop};
  endfunction

  task automatic run_instr(input logic [15:0] ins, output int low);
    @(negedge clk);
    instr = ins;
    s     = 1'b1;
    @(negedge clk);
    s     = 1'b0;
    instr = ~ins;
    low   = 0;
    while (!w && low < 20) begin
      low++;
      @(negedge clk);
    end
  endtask

  int low;

  initial begin
    n_chk = 0;
    n_ok  = 0;
    rst_n = 1'b0;
    s     = 1'b0;
    instr = 16'h0;
    init  = 1'b1;
    watch = 1'b0;
    seen  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_w", {31'b0, w}, 32'd1);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_strobes", {14'b0, strobes()}, 32'd0);
    chk("rst_dpin", {16'b0, datapath_in}, 32'd0);
    rst_n = 1'b1;
    init  = 1'b0;
    @(negedge clk);

    run_instr(16'hD007, low);
    chk("movi0_low", low, 2);
    chk("movi0_r0", {16'b0, rf[0]}, 32'd7);
    run_instr(16'hD102, low);
    chk("movi1_low", low, 2);
    chk("movi1_r1", {16'b0, rf[1]}, 32'd2);

    run_instr(16'hA148, low);
    chk("add_low", low, 5);
    chk("add_r2", {16'b0, rf[2]}, 32'd16);
    chk("add_r0", {16'b0, rf[0]}, 32'd7);
    chk("add_r1", {16'b0, rf[1]}, 32'd2);

    run_instr(16'hD3FF, low);
    chk("movneg_low", low, 2);
    chk("movneg_r3", {16'b0, rf[3]}, 32'hFFFF);

    run_instr(16'hA800, low);
    chk("cmp_low", low, 4);
    chk("cmp_z", {31'b0, z}, 32'd1);
    chk("cmp_r0", {16'b0, rf[0]}, 32'd7);
    chk("cmp_r2", {16'b0, rf[2]}, 32'd16);
    chk("cmp_r3", {16'b0, rf[3]}, 32'hFFFF);

    seen  = 1'b0;
    watch = 1'b1;
    run_instr(16'hE000, low);
    repeat (3) @(negedge clk);
    watch = 1'b0;
    chk("ill_nostrobe", {31'b0, seen}, 32'd0);
`ifdef DATAPATH_CTRL_TRAP_EN
    chk("ill_trap_low", low, 20);
    chk("ill_trap_w", {31'b0, w}, 32'd0);
    chk("ill_trap_err", {31'b0, err}, 32'd1);
`else
    chk("ill_low", low, 1);
    chk("ill_w", {31'b0, w}, 32'd1);
    chk("ill_err", {31'b0, err}, 32'd0);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("ill_rst_err", {31'b0, err}, 32'd0);
    chk("ill_rst_w", {31'b0, w}, 32'd1);

    @(negedge clk);
    instr = 16'hA143;
    s     = 1'b1;
    @(negedge clk);
    s     = 1'b0;
    repeat (3) @(negedge clk);
    chk("exec_loadc", {31'b0, loadc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_w", {31'b0, w}, 32'd1);
    chk("midrst_strobes", {14'b0, strobes()}, 32'd0);
    chk("midrst_dpin", {16'b0, datapath_in}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_r2", {16'b0, rf[2]}, 32'd16);
    chk("midrst_idle", {31'b0, w}, 32'd1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
